// File: rtl/bus_msg_pkg.sv
// Shared coherence-bus message codes, responder state encoding and a ceiling-log2 helper.
package bus_msg_pkg;

  localparam int unsigned NO_REQ     = 0;
  localparam int unsigned R_REQ      = 1;
  localparam int unsigned WB_REQ     = 2;
  localparam int unsigned MEM_RESP   = 8;
  localparam int unsigned MEM_WB_ACK = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MRD   = 3'd1,
    SEND  = 3'd2,
    WBC   = 3'd3,
    MWR   = 3'd4,
    ACK   = 3'd5,
    DRAIN = 3'd6
  } state_t;

  // Smallest r with (1 << r) >= value.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Memory-line register addressed in bus beats, with per-word write-enable tracking.
module line_beat_buffer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BUS_OFFSET_BITS = 0,
  parameter int unsigned MAX_OFFSET_BITS = 3,
  localparam int unsigned WPB       = 1 << BUS_OFFSET_BITS,
  localparam int unsigned BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS,
  localparam int unsigned MEM_WIDTH = DATA_WIDTH << MAX_OFFSET_BITS,
  localparam int unsigned MAX_WORDS = 1 << MAX_OFFSET_BITS,
  localparam int unsigned BEAT_BITS = MAX_OFFSET_BITS - BUS_OFFSET_BITS,
  localparam int unsigned IDX_W     = (BEAT_BITS > 0) ? BEAT_BITS : 1,
  localparam int unsigned NBEATS    = 1 << BEAT_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [MEM_WIDTH-1:0] load_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [BUS_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [MEM_WIDTH-1:0] line,
  output logic [MAX_WORDS-1:0] word_en,
  output logic [BUS_WIDTH-1:0] rd_data
);

  logic [NBEATS-1:0][BUS_WIDTH-1:0] line_q;
  logic [NBEATS-1:0][WPB-1:0]       wen_q;
  logic [NBEATS-1:0][BUS_WIDTH-1:0] src;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_q <= '0;
      wen_q  <= '0;
    end else begin
      if (load) line_q <= load_line;
      if (clear || load) wen_q <= '0;
      if (wr_en) begin
        line_q[wr_idx] <= wr_data;
        wen_q[wr_idx]  <= '1;
      end
    end
  end

  // Reads see a line being loaded this cycle so the first beat needs no extra cycle.
  assign src     = load ? load_line : line_q;
  assign rd_data = src[rd_idx];
  assign line    = line_q;
  assign word_en = wen_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder of the coherence bus: serves R_REQ reads and collects WB_REQ write-backs.
// Define RESP_WB_FORWARD_EN to serve reads of the last fully written line without a memory read.
module mem_bus_responder
  import bus_msg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned MSG_BITS        = 4,
  parameter int unsigned BUS_OFFSET_BITS = 0,
  parameter int unsigned MAX_OFFSET_BITS = 3,
  localparam int unsigned BUS_WIDTH = DATA_WIDTH << BUS_OFFSET_BITS,
  localparam int unsigned MEM_WIDTH = DATA_WIDTH << MAX_OFFSET_BITS,
  localparam int unsigned MAX_WORDS = 1 << MAX_OFFSET_BITS,
  localparam int unsigned OFF_W     = log2(MAX_OFFSET_BITS) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     bus_msg_in,
  input  logic [ADDRESS_BITS-1:0] bus_address_in,
  input  logic [BUS_WIDTH-1:0]    bus_data_in,
  input  logic                    bus_master,
  input  logic [OFF_W-1:0]        curr_offset,
  output logic                    req_ready,
  output logic [MSG_BITS-1:0]     bus_msg_out,
  output logic [ADDRESS_BITS-1:0] bus_address_out,
  output logic [BUS_WIDTH-1:0]    bus_data_out,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [MEM_WIDTH-1:0]    mem_data_out,
  output logic [MAX_WORDS-1:0]    mem_word_en,
  input  logic [MEM_WIDTH-1:0]    mem_data_in,
  input  logic                    mem_ready,
  input  logic                    mem_valid
);

  localparam int unsigned BEAT_BITS = MAX_OFFSET_BITS - BUS_OFFSET_BITS;
  localparam int unsigned IDX_W     = (BEAT_BITS > 0) ? BEAT_BITS : 1;
  localparam int unsigned CNT_W     = BEAT_BITS + 1;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n, beats_q, beats_c;
  logic [ADDRESS_BITS-1:0] base_q, base_n, req_base_c, line_addr_c;
  logic [OFF_W-1:0]        eff_off;
  logic                    off_low, accept;

  logic                    buf_clear, buf_load, buf_wr_en;
  logic [MEM_WIDTH-1:0]    buf_load_line, buf_line;
  logic [MAX_WORDS-1:0]    buf_word_en;
  logic [IDX_W-1:0]        buf_wr_idx, buf_rd_idx;
  logic [BUS_WIDTH-1:0]    buf_rd_data;

  logic                    req_ready_n, mem_read_n, mem_write_n;
  logic [MSG_BITS-1:0]     msg_n;
  logic [ADDRESS_BITS-1:0] baddr_n;
  logic [BUS_WIDTH-1:0]    bdata_n;
  logic [MEM_WIDTH-1:0]    mdata_n;
  logic [MAX_WORDS-1:0]    wen_n;

  logic                    fwd_hit;
  logic [MEM_WIDTH-1:0]    fwd_line;

  function automatic logic [IDX_W-1:0] beat_idx(input logic [ADDRESS_BITS-1:0] a);
    return IDX_W'(a >> BUS_OFFSET_BITS);
  endfunction

  // Out-of-range requester offsets collapse to a single bus beat.
  if (BUS_OFFSET_BITS == 0) begin : g_no_low
    assign off_low = 1'b0;
  end else begin : g_low
    assign off_low = curr_offset < OFF_W'(BUS_OFFSET_BITS);
  end

  assign eff_off     = (off_low || curr_offset > OFF_W'(MAX_OFFSET_BITS))
                       ? OFF_W'(BUS_OFFSET_BITS) : curr_offset;
  assign req_base_c  = bus_address_in & ~((ADDRESS_BITS'(1) << eff_off) - ADDRESS_BITS'(1));
  assign line_addr_c = bus_address_in & ~ADDRESS_BITS'(MAX_WORDS - 1);
  assign beats_c     = CNT_W'(1) << (eff_off - OFF_W'(BUS_OFFSET_BITS));
  assign buf_wr_idx  = beat_idx(bus_address_in);
  assign buf_rd_idx  = beat_idx(base_n) + IDX_W'(cnt_n);

  line_beat_buffer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BUS_OFFSET_BITS(BUS_OFFSET_BITS),
    .MAX_OFFSET_BITS(MAX_OFFSET_BITS)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .clear    (buf_clear),
    .load     (buf_load),
    .load_line(buf_load_line),
    .wr_en    (buf_wr_en),
    .wr_idx   (buf_wr_idx),
    .wr_data  (bus_data_in),
    .rd_idx   (buf_rd_idx),
    .line     (buf_line),
    .word_en  (buf_word_en),
    .rd_data  (buf_rd_data)
  );

`ifdef RESP_WB_FORWARD_EN
  logic                    fwd_valid;
  logic [ADDRESS_BITS-1:0] fwd_addr;
  logic [MEM_WIDTH-1:0]    fwd_line_q;

  // Only a completely written line can stand in for memory contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_line_q <= '0;
    end else if (state == MWR && mem_ready) begin
      fwd_valid  <= &buf_word_en;
      fwd_addr   <= mem_address;
      fwd_line_q <= buf_line;
    end
  end

  assign fwd_hit  = fwd_valid && (fwd_addr == line_addr_c);
  assign fwd_line = fwd_line_q;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_line = '0;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt_q;
    base_n        = base_q;
    accept        = 1'b0;
    buf_clear     = 1'b0;
    buf_load      = 1'b0;
    buf_load_line = mem_data_in;
    buf_wr_en     = 1'b0;
    msg_n         = MSG_BITS'(NO_REQ);
    baddr_n       = '0;
    bdata_n       = '0;
    mdata_n       = '0;
    wen_n         = '0;
    case (state)
      IDLE: begin
        if (bus_master && bus_msg_in == MSG_BITS'(R_REQ)) begin
          accept = 1'b1;
          base_n = req_base_c;
          cnt_n  = '0;
          if (fwd_hit) begin
            state_n       = SEND;
            buf_load      = 1'b1;
            buf_load_line = fwd_line;
          end else begin
            state_n = MRD;
          end
        end else if (bus_master && bus_msg_in == MSG_BITS'(WB_REQ)) begin
          accept    = 1'b1;
          base_n    = req_base_c;
          cnt_n     = CNT_W'(1);
          buf_clear = 1'b1;
          buf_wr_en = 1'b1;
          state_n   = WBC;
        end
      end
      MRD: begin
        if (!bus_master) begin
          state_n = mem_valid ? IDLE : DRAIN;
        end else if (mem_valid) begin
          buf_load = 1'b1;
          cnt_n    = '0;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (!bus_master || cnt_q == beats_q - CNT_W'(1)) state_n = IDLE;
        else cnt_n = cnt_q + CNT_W'(1);
      end
      WBC: begin
        if (!bus_master) begin
          state_n = IDLE;
        end else if (cnt_q == beats_q) begin
          state_n = MWR;
        end else if (bus_msg_in == MSG_BITS'(WB_REQ)) begin
          buf_wr_en = 1'b1;
          cnt_n     = cnt_q + CNT_W'(1);
        end
      end
      MWR:     if (mem_ready) state_n = ACK;
      ACK:     state_n = IDLE;
      DRAIN:   if (mem_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    req_ready_n = (state_n == IDLE);
    mem_read_n  = (state_n == MRD);
    mem_write_n = (state_n == MWR);
    if (state_n == SEND) begin
      msg_n   = MSG_BITS'(MEM_RESP);
      baddr_n = base_n + (ADDRESS_BITS'(cnt_n) << BUS_OFFSET_BITS);
      bdata_n = buf_rd_data;
    end else if (state_n == ACK) begin
      msg_n   = MSG_BITS'(MEM_WB_ACK);
      baddr_n = base_q;
    end
    if (state_n == MWR) begin
      mdata_n = buf_line;
      wen_n   = buf_word_en;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt_q           <= '0;
      beats_q         <= '0;
      base_q          <= '0;
      req_ready       <= 1'b1;
      bus_msg_out     <= MSG_BITS'(NO_REQ);
      bus_address_out <= '0;
      bus_data_out    <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_data_out    <= '0;
      mem_word_en     <= '0;
    end else begin
      state           <= state_n;
      cnt_q           <= cnt_n;
      base_q          <= base_n;
      req_ready       <= req_ready_n;
      bus_msg_out     <= msg_n;
      bus_address_out <= baddr_n;
      bus_data_out    <= bdata_n;
      mem_read        <= mem_read_n;
      mem_write       <= mem_write_n;
      mem_data_out    <= mdata_n;
      mem_word_en     <= wen_n;
      if (accept) begin
        beats_q     <= beats_c;
        mem_address <= line_addr_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: vector table for a read, hand sequences for multi-cycle cases.
module tb_mem_bus_responder;
  import bus_msg_pkg::*;

  logic         clock, reset, bus_master, mem_ready, mem_valid;
  logic [3:0]   bus_msg_in;
  logic [31:0]  bus_address_in, bus_data_in;
  logic [2:0]   curr_offset;
  logic [255:0] mem_data_in;
  logic         req_ready, mem_read, mem_write;
  logic [3:0]   bus_msg_out;
  logic [31:0]  bus_address_out, bus_data_out, mem_address;
  logic [255:0] mem_data_out;
  logic [7:0]   mem_word_en;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0][31:0] line_a, line_b, line_c, mdo;

  typedef struct {
    logic        master;
    logic [3:0]  msg;
    logic [31:0] addr;
    logic [2:0]  off;
    logic        mv;
    logic        e_rdy;
    logic        e_rd;
    logic [3:0]  e_msg;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;
  vec_t tab [8];

  mem_bus_responder dut (
    .clock(clock), .reset(reset), .bus_msg_in(bus_msg_in), .bus_address_in(bus_address_in),
    .bus_data_in(bus_data_in), .bus_master(bus_master), .curr_offset(curr_offset),
    .req_ready(req_ready), .bus_msg_out(bus_msg_out), .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_word_en(mem_word_en),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .mem_valid(mem_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mkv(input logic m, input logic [3:0] msg, input logic [31:0] a,
                               input logic [2:0] o, input logic mv, input logic rdy, input logic rd,
                               input logic [3:0] em, input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.master = m; v.msg = msg; v.addr = a; v.off = o; v.mv = mv;
    v.e_rdy = rdy; v.e_rd = rd; v.e_msg = em; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus_master = 1'b0; bus_msg_in = 4'(NO_REQ); bus_address_in = '0; bus_data_in = '0;
    curr_offset = '0; mem_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic req(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] o);
    bus_master = 1'b1; bus_msg_in = m; bus_address_in = a; bus_data_in = d; curr_offset = o;
    tick();
  endtask

  task automatic hold();
    bus_msg_in = 4'(NO_REQ); bus_address_in = '0; bus_data_in = '0;
    tick();
  endtask

  task automatic chk_beat(input string name, input logic [31:0] a, input logic [31:0] d);
    chk({name, ".msg"}, 256'(bus_msg_out), 256'(MEM_RESP));
    chk({name, ".addr"}, 256'(bus_address_out), 256'(a));
    chk({name, ".data"}, 256'(bus_data_out), 256'(d));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      line_a[k] = 32'hA0 + 32'(k);
      line_b[k] = 32'hB0 + 32'(k);
      line_c[k] = 32'hC000_0000 + 32'(k);
    end
    idle_in();
    mem_data_in = line_a;
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst.ready", 256'(req_ready), 256'(1'b1));
    chk("rst.msg", 256'(bus_msg_out), 256'(NO_REQ));
    chk("rst.mem_read", 256'(mem_read), 256'(1'b0));
    chk("rst.mem_write", 256'(mem_write), 256'(1'b0));
    chk("rst.mem_addr", 256'(mem_address), 256'(0));
    reset = 1'b0;
    tick();

    // Read of a 4-word line at 0x104, memory answers on the fourth cycle.
    tab[0] = mkv(1'b1, 4'(R_REQ),  32'h104, 3'd2, 1'b0, 1'b0, 1'b1, 4'(NO_REQ),   32'h0,   32'h0);
    tab[1] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b0, 1'b0, 1'b1, 4'(NO_REQ),   32'h0,   32'h0);
    tab[2] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b0, 1'b0, 1'b1, 4'(NO_REQ),   32'h0,   32'h0);
    tab[3] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b1, 1'b0, 1'b0, 4'(MEM_RESP), 32'h104, 32'hA4);
    tab[4] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b0, 1'b0, 1'b0, 4'(MEM_RESP), 32'h105, 32'hA5);
    tab[5] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b0, 1'b0, 1'b0, 4'(MEM_RESP), 32'h106, 32'hA6);
    tab[6] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b0, 1'b0, 1'b0, 4'(MEM_RESP), 32'h107, 32'hA7);
    tab[7] = mkv(1'b1, 4'(NO_REQ), 32'h0,   3'd2, 1'b0, 1'b1, 1'b0, 4'(NO_REQ),   32'h0,   32'h0);
    for (int i = 0; i < 8; i++) begin
      bus_master = tab[i].master; bus_msg_in = tab[i].msg; bus_address_in = tab[i].addr;
      curr_offset = tab[i].off; mem_valid = tab[i].mv;
      tick();
      chk($sformatf("rd%0d.ready", i), 256'(req_ready), 256'(tab[i].e_rdy));
      chk($sformatf("rd%0d.mem_read", i), 256'(mem_read), 256'(tab[i].e_rd));
      chk($sformatf("rd%0d.msg", i), 256'(bus_msg_out), 256'(tab[i].e_msg));
      chk($sformatf("rd%0d.addr", i), 256'(bus_address_out), 256'(tab[i].e_addr));
      chk($sformatf("rd%0d.data", i), 256'(bus_data_out), 256'(tab[i].e_data));
    end
    chk("rd.mem_addr", 256'(mem_address), 256'(32'h100));

    // Out-of-range offset is a single beat.
    req(4'(R_REQ), 32'h103, 32'h0, 3'd5);
    mem_valid = 1'b1; hold(); mem_valid = 1'b0;
    chk_beat("big_off", 32'h103, 32'hA3);
    hold();
    chk("big_off.end", 256'(bus_msg_out), 256'(NO_REQ));

    // Full-line write-back with a two-cycle gap before beat 3.
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin hold(); hold(); end
      req(4'(WB_REQ), 32'h200 + 32'(k), line_b[k], 3'd3);
      chk($sformatf("wb%0d.no_write", k), 256'(mem_write), 256'(1'b0));
    end
    hold();
    chk("wb.mem_write", 256'(mem_write), 256'(1'b1));
    chk("wb.word_en", 256'(mem_word_en), 256'(8'hFF));
    chk("wb.data", mem_data_out, 256'(line_b));
    chk("wb.mem_addr", 256'(mem_address), 256'(32'h200));
    hold();
    chk("wb.write_held", 256'(mem_write), 256'(1'b1));
    mem_ready = 1'b1; hold(); mem_ready = 1'b0;
    chk("wb.ack_msg", 256'(bus_msg_out), 256'(MEM_WB_ACK));
    chk("wb.ack_addr", 256'(bus_address_out), 256'(32'h200));
    chk("wb.write_done", 256'(mem_write), 256'(1'b0));
    hold();
    chk("wb.end_msg", 256'(bus_msg_out), 256'(NO_REQ));
    chk("wb.end_ready", 256'(req_ready), 256'(1'b1));

    // Two-word write-back into the middle of a memory line.
    req(4'(WB_REQ), 32'h30A, 32'hD0, 3'd1);
    req(4'(WB_REQ), 32'h30B, 32'hD1, 3'd1);
    hold();
    mdo = mem_data_out;
    chk("wb2.mem_write", 256'(mem_write), 256'(1'b1));
    chk("wb2.mem_addr", 256'(mem_address), 256'(32'h308));
    chk("wb2.word_en", 256'(mem_word_en), 256'(8'h0C));
    chk("wb2.word2", 256'(mdo[2]), 256'(32'hD0));
    chk("wb2.word3", 256'(mdo[3]), 256'(32'hD1));
    mem_ready = 1'b1; hold(); mem_ready = 1'b0;
    chk("wb2.ack_addr", 256'(bus_address_out), 256'(32'h30A));
    hold();

    // Master drops after two beats.
    req(4'(R_REQ), 32'h104, 32'h0, 3'd2);
    mem_valid = 1'b1; hold(); mem_valid = 1'b0;
    chk_beat("abort.b0", 32'h104, 32'hA4);
    hold();
    chk_beat("abort.b1", 32'h105, 32'hA5);
    bus_master = 1'b0; hold();
    chk("abort.msg", 256'(bus_msg_out), 256'(NO_REQ));
    chk("abort.ready", 256'(req_ready), 256'(1'b1));

    // Master drops while waiting for memory: drain the pending read.
    req(4'(R_REQ), 32'h104, 32'h0, 3'd2);
    bus_master = 1'b0; hold();
    chk("drain.mem_read", 256'(mem_read), 256'(1'b0));
    chk("drain.ready", 256'(req_ready), 256'(1'b0));
    hold();
    chk("drain.wait", 256'(req_ready), 256'(1'b0));
    mem_valid = 1'b1; hold(); mem_valid = 1'b0;
    chk("drain.msg", 256'(bus_msg_out), 256'(NO_REQ));
    chk("drain.ready_back", 256'(req_ready), 256'(1'b1));
    hold();
    chk("drain.no_resp", 256'(bus_msg_out), 256'(NO_REQ));

    // Reset in the middle of collecting a write-back.
    req(4'(WB_REQ), 32'h200, 32'hE0, 3'd3);
    req(4'(WB_REQ), 32'h201, 32'hE1, 3'd3);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst.ready", 256'(req_ready), 256'(1'b1));
    chk("mid_rst.msg", 256'(bus_msg_out), 256'(NO_REQ));
    chk("mid_rst.mem_addr", 256'(mem_address), 256'(0));
    chk("mid_rst.word_en", 256'(mem_word_en), 256'(0));
    idle_in();
    tick();
    reset = 1'b0;
    req(4'(R_REQ), 32'h100, 32'h0, 3'd2);
    chk("post_rst.mem_read", 256'(mem_read), 256'(1'b1));
    mem_valid = 1'b1; hold(); mem_valid = 1'b0;
    chk_beat("post_rst.b0", 32'h100, 32'hA0);
    hold(); hold(); hold();
    chk_beat("post_rst.b3", 32'h103, 32'hA3);
    hold();
    chk("post_rst.end", 256'(bus_msg_out), 256'(NO_REQ));

`ifdef RESP_WB_FORWARD_EN
    // Read of the line just written is served from the forward register.
    for (int k = 0; k < 8; k++) req(4'(WB_REQ), 32'h400 + 32'(k), line_c[k], 3'd3);
    hold();
    mem_ready = 1'b1; hold(); mem_ready = 1'b0;
    hold();
    req(4'(R_REQ), 32'h400, 32'h0, 3'd3);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) hold();
      chk($sformatf("fwd%0d.mem_read", k), 256'(mem_read), 256'(1'b0));
      chk_beat($sformatf("fwd%0d", k), 32'h400 + 32'(k), line_c[k]);
    end
    hold();
    chk("fwd.end", 256'(bus_msg_out), 256'(NO_REQ));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
